// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter for a shared single-port instruction BRAM
// Optional feature: define IMEM_ARB_LOCK_EN to add the l_lock atomic-download input.
module imem_arbiter #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] BASE_ADDRESS = '0,
  parameter int              MEM_DEPTH    = 2000,
  parameter int              IDX_W        = 11,
  parameter int              STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [SIZE-1:0]  f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [SIZE-1:0]  f_rdata,
  output logic             f_err,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [SIZE-1:0]  l_addr,
  input  logic [SIZE-1:0]  l_wdata,
`ifdef IMEM_ARB_LOCK_EN
  input  logic             l_lock,
`endif
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [SIZE-1:0]  l_rdata,
  output logic             l_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [SIZE-1:0]  mem_wdata,
  input  logic [SIZE-1:0]  mem_rdata
);

  localparam logic [SIZE-1:0] NOP = SIZE'(32'h00000013);

  typedef enum logic [1:0] {OWN_IDLE, OWN_FETCH, OWN_LOAD} owner_t;

  owner_t          owner_q, owner_d;
  logic            bad_q, bad_d;
  logic            wr_q, wr_d;
  logic [7:0]      starve_q, starve_d;
  logic [SIZE-1:0] f_rdata_q, f_rdata_d;
  logic [SIZE-1:0] l_rdata_q, l_rdata_d;
  logic            lock_q, lock_d;

  logic [SIZE-1:0] f_word, l_word;
  logic            f_ok, l_ok;
  logic            lock_blk, starve_hit;

  // Addresses below BASE_ADDRESS wrap to huge word indices and fail the range check.
  always_comb begin
    f_word = (f_addr - BASE_ADDRESS) >> 2;
    l_word = (l_addr - BASE_ADDRESS) >> 2;
    f_ok   = (f_addr[1:0] == 2'b00) && (f_word < SIZE'(MEM_DEPTH));
    l_ok   = (l_addr[1:0] == 2'b00) && (l_word < SIZE'(MEM_DEPTH));
  end

  always_comb begin
    lock_blk   = lock_q;
    starve_hit = (starve_q == 8'(STARVE_LIMIT)) && !lock_blk;
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    if (!rst) begin
      if (l_req && (!f_req || lock_blk || !starve_hit)) l_gnt = 1'b1;
      else if (f_req && !lock_blk)                      f_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IDLE;
      bad_q     <= 1'b0;
      wr_q      <= 1'b0;
      starve_q  <= 8'd0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      bad_q     <= bad_d;
      wr_q      <= wr_d;
      starve_q  <= starve_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
      lock_q    <= lock_d;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    bad_d   = 1'b0;
    wr_d    = 1'b0;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
      bad_d   = !f_ok;
    end else if (l_gnt) begin
      owner_d = OWN_LOAD;
      bad_d   = !l_ok;
      wr_d    = l_we;
    end

    starve_d = starve_q;
    if (!f_req || f_gnt || lock_blk) starve_d = 8'd0;
    else if (l_gnt && starve_q != 8'hFF) starve_d = starve_q + 8'd1;

`ifdef IMEM_ARB_LOCK_EN
    lock_d = l_lock ? (lock_q | l_gnt) : 1'b0;
`else
    lock_d = 1'b0;
`endif

    // Read data lands the cycle after the grant; otherwise each port keeps its last word.
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    if (owner_q == OWN_FETCH) f_rdata_d = bad_q ? NOP : mem_rdata;
    if (owner_q == OWN_LOAD && !wr_q) l_rdata_d = bad_q ? NOP : mem_rdata;
  end

  always_comb begin
    f_rvalid  = (owner_q == OWN_FETCH);
    f_err     = (owner_q == OWN_FETCH) && bad_q;
    f_rdata   = f_rdata_d;
    l_rvalid  = (owner_q == OWN_LOAD) && !wr_q;
    l_err     = (owner_q == OWN_LOAD) && bad_q;
    l_rdata   = l_rdata_d;
    mem_en    = (f_gnt && f_ok) || (l_gnt && l_ok);
    mem_we    = l_gnt && l_we && l_ok;
    mem_addr  = l_gnt ? l_word[IDX_W-1:0] : f_word[IDX_W-1:0];
    mem_wdata = l_wdata;
  end

endmodule
